// File: rtl/m16_imit_pkg.sv
// Shared encodings for the M16 imitator pattern writer: FSM states, pattern modes, LFSR taps.
package m16_imit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_WRITE   = 3'd2,
        ST_HOLD    = 3'd3,
        ST_ADVANCE = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        MODE_INCR = 2'd0,
        MODE_WALK = 2'd1,
        MODE_ONES = 2'd2,
        MODE_LFSR = 2'd3
    } mode_e;

    // Bit i set means term x^(i+1) of the feedback polynomial (x^10 + x^7 + 1).
    localparam logic [9:0] LFSR_TAPS = 10'h240;

endpackage

// File: rtl/pattern_ram_writer_toggle_sync.sv
// Two-flop synchroniser plus edge flop; emits a one-cycle pulse on any level change of din.
module toggle_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic toggle
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Reset loads the current input level so that releasing reset never looks like a toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= din;
            sync_q <= din;
            prev_q <= din;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign toggle = sync_q ^ prev_q;

endmodule

// File: rtl/pattern_ram_writer.sv
// Writes one frame of pattern words into the frame RAM per switch toggle.
// Define PATTERN_LFSR_EN to make mode 3 a Galois LFSR; otherwise mode 3 counts like mode 0.
module pattern_ram_writer
    import m16_imit_pkg::*;
#(
    parameter int CNT_W           = 10,
    parameter int DATA_W          = 12,
    parameter int ADDR_W          = 11,
    parameter int STRIDE          = 256,
    parameter int ADDR_LIMIT      = 2000,
    parameter int WORDS_PER_FRAME = 8,
    parameter int CNT_MAX         = 1023,
    parameter int WREN_CYCLES     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              switch,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] address,
    output logic              wren,
    output logic              busy,
    output logic              frame_done,
    output logic              test
);

    localparam int IDX_W = $clog2(WORDS_PER_FRAME + 1);
    localparam int WC_W  = $clog2(WREN_CYCLES + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS_PER_FRAME - 1);
    localparam logic [WC_W-1:0]   LAST_WC  = WC_W'(WREN_CYCLES - 1);
    localparam logic [ADDR_W:0]   STRIDE_X = (ADDR_W + 1)'(STRIDE);
    localparam logic [ADDR_W:0]   LIMIT_X  = (ADDR_W + 1)'(ADDR_LIMIT);
    localparam logic [CNT_W-1:0]  CNT_TOP  = CNT_W'(CNT_MAX);

    state_e            state_q,   state_d;
    mode_e             mode_q,    mode_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [CNT_W-1:0]  count_q,   count_d;
    logic [CNT_W-1:0]  walk_q,    walk_d;
    logic [IDX_W-1:0]  idx_q,     idx_d;
    logic [WC_W-1:0]   wcnt_q,    wcnt_d;
    logic              pend_q,    pend_d;
    logic [DATA_W-1:0] data_q,    data_d;
    logic              wren_q,    wren_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic              test_q,    test_d;
`ifdef PATTERN_LFSR_EN
    localparam logic [CNT_W-1:0] TAPS = CNT_W'(LFSR_TAPS);
    logic [CNT_W-1:0]  lfsr_q,    lfsr_d;
`endif

    logic              toggle_s;
    logic              start_s;
    logic [ADDR_W:0]   addr_sum_s;
    logic [CNT_W-1:0]  pat_s;
    mode_e             mode_in_s;

    toggle_sync u_sync (
        .clk    (clk),
        .rst_n  (reset),
        .din    (switch),
        .toggle (toggle_s)
    );

    // Next-state, datapath and registered-output logic for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        address_d  = address_q;
        count_d    = count_q;
        walk_d     = walk_q;
        idx_d      = idx_q;
        wcnt_d     = wcnt_q;
        pend_d     = pend_q;
        start_s    = 1'b0;
        addr_sum_s = {1'b0, address_q} + STRIDE_X;
`ifdef PATTERN_LFSR_EN
        lfsr_d     = lfsr_q;
        mode_in_s  = mode_e'(mode);
`else
        mode_in_s  = (mode_e'(mode) == MODE_LFSR) ? MODE_INCR : mode_e'(mode);
`endif

        case (state_q)
            ST_IDLE: begin
                if (toggle_s || pend_q) begin
                    start_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                wcnt_d  = '0;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (wcnt_q == LAST_WC) begin
                    state_d = ST_HOLD;
                end else begin
                    wcnt_d = wcnt_q + WC_W'(1);
                end
            end
            ST_HOLD: begin
                state_d = ST_ADVANCE;
            end
            ST_ADVANCE: begin
                address_d = (addr_sum_s > LIMIT_X) ? '0 : addr_sum_s[ADDR_W-1:0];
                case (mode_q)
                    MODE_INCR: count_d = (count_q == CNT_TOP) ? '0 : count_q + CNT_W'(1);
                    MODE_WALK: walk_d  = {walk_q[CNT_W-2:0], walk_q[CNT_W-1]};
                    MODE_ONES: walk_d  = walk_q;
`ifdef PATTERN_LFSR_EN
                    MODE_LFSR: lfsr_d  = {lfsr_q[CNT_W-2:0], 1'b0}
                                         ^ ({CNT_W{lfsr_q[CNT_W-1]}} & {TAPS[CNT_W-2:0], 1'b1});
`endif
                    default:   count_d = (count_q == CNT_TOP) ? '0 : count_q + CNT_W'(1);
                endcase
                idx_d = idx_q + IDX_W'(1);
                if (idx_q != LAST_IDX) begin
                    state_d = ST_SETUP;
                end else if (pend_q) begin
                    start_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Toggles seen mid-frame collapse into a single queued request.
        if (toggle_s && (state_q != ST_IDLE)) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_d;
        end

        if (start_s) begin
            state_d = ST_SETUP;
            mode_d  = mode_in_s;
            pend_d  = 1'b0;
            idx_d   = '0;
        end else begin
            mode_d  = mode_d;
        end

        case (mode_d)
            MODE_WALK: pat_s = walk_d;
            MODE_ONES: pat_s = {CNT_W{1'b1}};
`ifdef PATTERN_LFSR_EN
            MODE_LFSR: pat_s = lfsr_d;
`endif
            default:   pat_s = count_d;
        endcase

        data_d = {1'b0, pat_s, 1'b0};
        wren_d = (state_d == ST_WRITE);
        busy_d = (state_d != ST_IDLE);
        test_d = (state_d == ST_IDLE);
        done_d = (state_d == ST_ADVANCE) && (idx_q == LAST_IDX);
    end

    // State and output registers; reset abandons any frame in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_INCR;
            address_q <= '0;
            count_q   <= '0;
            walk_q    <= CNT_W'(1);
            idx_q     <= '0;
            wcnt_q    <= '0;
            pend_q    <= 1'b0;
            data_q    <= '0;
            wren_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            test_q    <= 1'b1;
`ifdef PATTERN_LFSR_EN
            lfsr_q    <= CNT_W'(1);
`endif
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            address_q <= address_d;
            count_q   <= count_d;
            walk_q    <= walk_d;
            idx_q     <= idx_d;
            wcnt_q    <= wcnt_d;
            pend_q    <= pend_d;
            data_q    <= data_d;
            wren_q    <= wren_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            test_q    <= test_d;
`ifdef PATTERN_LFSR_EN
            lfsr_q    <= lfsr_d;
`endif
        end
    end

    assign data       = data_q;
    assign address    = address_q;
    assign wren       = wren_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign test       = test_q;

endmodule

// File: tb/tb_pattern_ram_writer.sv
// Scoreboard bench for pattern_ram_writer: expected words are queued per triggered frame.
module tb_pattern_ram_writer;

`ifdef PATTERN_LFSR_EN
    localparam bit LFSR_ON = 1'b1;
`else
    localparam bit LFSR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        switch;
    logic [1:0]  mode;
    logic [11:0] data;
    logic [10:0] address;
    logic        wren;
    logic        busy;
    logic        frame_done;
    logic        test;

    typedef struct packed {
        logic [10:0] a;
        logic [11:0] d;
    } exp_t;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [10:0] m_addr;
    logic [9:0]  m_count;
    logic [9:0]  m_walk;
    logic [9:0]  m_lfsr;

    pattern_ram_writer dut (
        .clk        (clk),
        .reset      (reset),
        .switch     (switch),
        .mode       (mode),
        .data       (data),
        .address    (address),
        .wren       (wren),
        .busy       (busy),
        .frame_done (frame_done),
        .test       (test)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_addr  = 11'd0;
        m_count = 10'd0;
        m_walk  = 10'd1;
        m_lfsr  = 10'd1;
    endtask

    task automatic push_frame(input int m);
        logic [9:0] pat;
        exp_t       e;
        int         nxt;
        logic       fb;
        for (int w = 0; w < 8; w++) begin
            if (m == 1)                 pat = m_walk;
            else if (m == 2)            pat = 10'h3FF;
            else if (m == 3 && LFSR_ON) pat = m_lfsr;
            else                        pat = m_count;
            e.a = m_addr;
            e.d = {1'b0, pat, 1'b0};
            q.push_back(e);
            nxt = int'(m_addr) + 256;
            m_addr = (nxt > 2000) ? 11'd0 : 11'(nxt);
            if (m == 1) begin
                m_walk = {m_walk[8:0], m_walk[9]};
            end else if (m == 2) begin
                m_walk = m_walk;
            end else if (m == 3 && LFSR_ON) begin
                fb     = m_lfsr[9];
                m_lfsr = {m_lfsr[8:0], fb} ^ (fb ? 10'h080 : 10'h000);
            end else begin
                m_count = (m_count == 10'd1023) ? 10'd0 : m_count + 10'd1;
            end
        end
    endtask

    // Write monitor: pops one expected word per wren burst and checks burst length and stability.
    initial begin
        int   run_len;
        logic wren_prev;
        logic has_cur;
        exp_t cur;
        run_len   = 0;
        wren_prev = 1'b0;
        has_cur   = 1'b0;
        cur       = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                run_len   = 0;
                wren_prev = 1'b0;
                has_cur   = 1'b0;
            end else begin
                if (wren === 1'b1 && !wren_prev) begin
                    checks++;
                    assert (q.size() > 0) else begin
                        failures++;
                        $error("FAIL unexpected_write observed=addr_0x%0h expected=no_write", address);
                    end
                    if (q.size() > 0) begin
                        cur     = q.pop_front();
                        has_cur = 1'b1;
                        check("write_addr", 32'(address), 32'(cur.a));
                        check("write_data", 32'(data), 32'(cur.d));
                    end else begin
                        has_cur = 1'b0;
                    end
                    run_len = 1;
                end else if (wren === 1'b1) begin
                    run_len++;
                    if (has_cur) begin
                        check("hold_addr", 32'(address), 32'(cur.a));
                        check("hold_data", 32'(data), 32'(cur.d));
                    end
                end else if (wren_prev) begin
                    check("wren_len", 32'(run_len), 32'd3);
                end
                wren_prev = (wren === 1'b1);
            end
        end
    end

    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        while (frame_done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 32'(frame_done), 32'd1);
    endtask

    task automatic run_frame(input int m, input bit chk_lat);
        int cyc;
        mode   = 2'(m);
        switch = ~switch;
        push_frame(m);
        cyc = 0;
        while (frame_done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 10) mode = ~mode;
            if (chk_lat && cyc == 2) check("busy_before_sync", 32'(busy), 32'd0);
            if (chk_lat && cyc == 3) check("busy_after_sync", 32'(busy), 32'd1);
        end
        check("frame_done_seen", 32'(frame_done), 32'd1);
        check("frame_latency", 32'(cyc), 32'd50);
        @(negedge clk);
        check("idle_test", 32'(test), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("frame_consumed", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int cyc;
        int extra;
        reset  = 1'b0;
        switch = 1'b0;
        mode   = 2'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_address", 32'(address), 32'd0);
        check("rst_wren", 32'(wren), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_test", 32'(test), 32'd1);
        check("rst_data", 32'(data), 32'd0);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check("no_frame_on_release", 32'(busy), 32'd0);

        run_frame(0, 1'b1);
        run_frame(0, 1'b0);
        run_frame(1, 1'b0);
        run_frame(2, 1'b0);
        run_frame(1, 1'b0);

        // Incrementing count reaches 1023 and wraps to 0 on a frame boundary.
        for (int i = 0; i < 127; i++) run_frame(0, 1'b0);

        mode   = 2'd0;
        switch = ~switch;
        push_frame(0);
        push_frame(0);
        repeat (10) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            switch = ~switch;
            repeat (5) @(negedge clk);
        end
        wait_done("pend_first_done", cyc);
        @(negedge clk);
        check("pend_start_busy", 32'(busy), 32'd1);
        check("pend_start_test", 32'(test), 32'd0);
        wait_done("pend_second_done", cyc);
        extra = 0;
        repeat (150) begin
            @(negedge clk);
            if (frame_done === 1'b1 || wren === 1'b1) extra++;
        end
        check("no_third_frame", 32'(extra), 32'd0);
        check("pend_consumed", 32'(q.size()), 32'd0);

        mode   = 2'd0;
        switch = ~switch;
        push_frame(0);
        repeat (29) @(negedge clk);
        check("pre_reset_wren", 32'(wren), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("midrst_wren", 32'(wren), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_address", 32'(address), 32'd0);
        check("midrst_test", 32'(test), 32'd1);
        q.delete();
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        extra = 0;
        repeat (100) begin
            @(negedge clk);
            if (wren === 1'b1 || busy === 1'b1) extra++;
        end
        check("quiet_after_reset", 32'(extra), 32'd0);

        run_frame(3, 1'b0);
        run_frame(3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
